// File: rtl/game_pkg.sv
// Shared types and constants for the game round controller.
//   round_state_t : 3-bit round FSM state; the encoding is also reported as state_code
//   MAX_LEVEL     : highest playable level
//   START_LIVES   : lives granted when a new game starts
//   MAX_LIVES     : ceiling for total_life
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SHOW    = 3'd2,
    ST_PLAY    = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_PENALTY = 3'd5,
    ST_OVER    = 3'd6,
    ST_WIN     = 3'd7
  } round_state_t;

  localparam logic [1:0] MAX_LEVEL   = 2'd3;
  localparam logic [2:0] START_LIVES = 3'd7;
  localparam logic [2:0] MAX_LIVES   = 3'd7;

endpackage

// File: rtl/round_timer.sv
// Free-running window timer with synchronous clear, count enable and terminal-count compare.
//   clk        : rising-edge clock
//   clear      : synchronous clear to zero; overrides enable
//   enable     : advance the count by one
//   terminal   : compare value
//   at_limit_c : combinational flag, high while count equals terminal
module round_timer #(
  parameter int unsigned TIMER_W = 28
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               enable,
  input  logic [TIMER_W-1:0] terminal,
  output logic               at_limit_c
);

  logic [TIMER_W-1:0] count;

  // Counter register
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TIMER_W'(1);
    end
  end

  assign at_limit_c = (count == terminal);

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer for the key-memory game: load, show, play, then advance or penalise.
// Optional feature macro: LIFE_BONUS_EN (each cleared level grants one life, capped at 7).
//   clk        : rising-edge clock
//   reset      : synchronous, active-low
//   start      : request a new game (honoured in IDLE, OVER and WIN only)
//   seq_done   : player finished the current key sequence (PLAY only)
//   miss       : wrong key pulse (PLAY only)
//   level      : current level 0..3
//   total_life : remaining lives
//   seq_reset  : one-cycle strobe to load a new sequence
//   show_en    : sequence display window
//   play_en    : key entry window
//   state_code : FSM state encoding
//   game_over  : high in OVER
//   win        : high in WIN
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned         TIMER_W     = 28,
  parameter logic [TIMER_W-1:0]  ROUND_LIMIT = 28'hFFFFFFF,
  parameter logic [TIMER_W-1:0]  SHOW_LIMIT  = 28'd50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       seq_done,
  input  logic       miss,
  output logic [1:0] level,
  output logic [2:0] total_life,
  output logic       seq_reset,
  output logic       show_en,
  output logic       play_en,
  output logic [2:0] state_code,
  output logic       game_over,
  output logic       win
);

  // Terminal counts: a window of N cycles ends when the timer reads N-1
  localparam logic [TIMER_W-1:0] ROUND_TC = TIMER_W'(ROUND_LIMIT - TIMER_W'(1));
  localparam logic [TIMER_W-1:0] SHOW_TC  = TIMER_W'(SHOW_LIMIT - TIMER_W'(1));

  round_state_t       state;
  round_state_t       state_next;
  logic               timer_clear;
  logic               timer_enable;
  logic               timer_done_c;
  logic [TIMER_W-1:0] timer_terminal;
  logic [2:0]         life_dec;

  // Window timer shared by SHOW and PLAY; cleared in every other state and on SHOW exit
  assign timer_enable   = (state == ST_SHOW) || (state == ST_PLAY);
  assign timer_terminal = (state == ST_SHOW) ? SHOW_TC : ROUND_TC;
  assign timer_clear    = !reset || !timer_enable || ((state == ST_SHOW) && timer_done_c);

  round_timer #(
    .TIMER_W (TIMER_W)
  ) u_round_timer (
    .clk        (clk),
    .clear      (timer_clear),
    .enable     (timer_enable),
    .terminal   (timer_terminal),
    .at_limit_c (timer_done_c)
  );

  // Saturating life decrement
  assign life_dec = (total_life == 3'd0) ? 3'd0 : total_life - 3'(1);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_OVER, ST_WIN: if (start) state_next = ST_LOAD;
      ST_LOAD:    state_next = ST_SHOW;
      ST_SHOW:    if (timer_done_c) state_next = ST_PLAY;
      ST_PLAY: begin
        // seq_done outranks miss and timeout
        if (seq_done) begin
          state_next = ST_ADVANCE;
        end else if (miss || timer_done_c) begin
          state_next = ST_PENALTY;
        end
      end
      ST_ADVANCE: state_next = (level == MAX_LEVEL) ? ST_WIN : ST_LOAD;
      ST_PENALTY: state_next = (life_dec == 3'd0) ? ST_OVER : ST_LOAD;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    seq_reset  = 1'b0;
    show_en    = 1'b0;
    play_en    = 1'b0;
    game_over  = 1'b0;
    win        = 1'b0;
    state_code = state;
    case (state)
      ST_LOAD: seq_reset = 1'b1;
      ST_SHOW: show_en   = 1'b1;
      ST_PLAY: play_en   = 1'b1;
      ST_OVER: game_over = 1'b1;
      ST_WIN:  win       = 1'b1;
      default: ;
    endcase
  end

  // Level and life bookkeeping
  always_ff @(posedge clk) begin
    if (!reset) begin
      level      <= 2'd0;
      total_life <= START_LIVES;
    end else begin
      case (state)
        ST_IDLE, ST_OVER, ST_WIN: begin
          if (start) begin
            level      <= 2'd0;
            total_life <= START_LIVES;
          end
        end
        ST_ADVANCE: begin
          if (level != MAX_LEVEL) level <= level + 2'(1);
`ifdef LIFE_BONUS_EN
          if (total_life != MAX_LIVES) total_life <= total_life + 3'(1);
`else
          total_life <= total_life;
`endif
        end
        ST_PENALTY: total_life <= life_dec;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Randomized self-checking bench for game_round_ctrl with a cycle-level reference model.
module tb_game_round_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       seq_done;
  logic       miss;
  logic [1:0] level;
  logic [2:0] total_life;
  logic       seq_reset;
  logic       show_en;
  logic       play_en;
  logic [2:0] state_code;
  logic       game_over;
  logic       win;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase number, cycles spent in current window, level, lives
  int m_st    = 0;
  int m_t     = 0;
  int m_level = 0;
  int m_life  = 7;

  localparam int SHOW_N  = 5;
  localparam int ROUND_N = 20;

  game_round_ctrl #(
    .TIMER_W     (28),
    .ROUND_LIMIT (28'd20),
    .SHOW_LIMIT  (28'd5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .seq_done   (seq_done),
    .miss       (miss),
    .level      (level),
    .total_life (total_life),
    .seq_reset  (seq_reset),
    .show_en    (show_en),
    .play_en    (play_en),
    .state_code (state_code),
    .game_over  (game_over),
    .win        (win)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Advance the model by one clock given the inputs sampled at that edge
  task automatic model_step(input logic r, input logic s, input logic d, input logic m);
    if (!r) begin
      m_st = 0; m_level = 0; m_life = 7; m_t = 0;
    end else if (m_st == 0 || m_st == 6 || m_st == 7) begin
      if (s) begin m_st = 1; m_level = 0; m_life = 7; end
    end else if (m_st == 1) begin
      m_st = 2; m_t = 0;
    end else if (m_st == 2) begin
      if (m_t == SHOW_N - 1) begin m_st = 3; m_t = 0; end
      else m_t++;
    end else if (m_st == 3) begin
      if (d) m_st = 4;
      else if (m) m_st = 5;
      else if (m_t == ROUND_N - 1) m_st = 5;
      else m_t++;
    end else if (m_st == 4) begin
      if (m_level == 3) m_st = 7;
      else begin m_level++; m_st = 1; end
`ifdef LIFE_BONUS_EN
      if (m_life < 7) m_life++;
`endif
    end else if (m_st == 5) begin
      if (m_life > 0) m_life--;
      m_st = (m_life == 0) ? 6 : 1;
    end
  endtask

  task automatic check_outputs();
    check_eq("state_code", 32'(state_code), 32'(m_st));
    check_eq("level",      32'(level),      32'(m_level));
    check_eq("total_life", 32'(total_life), 32'(m_life));
    check_eq("seq_reset",  32'(seq_reset),  32'(m_st == 1));
    check_eq("show_en",    32'(show_en),    32'(m_st == 2));
    check_eq("play_en",    32'(play_en),    32'(m_st == 3));
    check_eq("game_over",  32'(game_over),  32'(m_st == 6));
    check_eq("win",        32'(win),        32'(m_st == 7));
  endtask

  // One clock: drive at negedge, model at posedge, compare at the next negedge
  task automatic cycle(input logic r, input logic s, input logic d, input logic m);
    reset = r; start = s; seq_done = d; miss = m;
    @(posedge clk);
    model_step(r, s, d, m);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_to_play();
    for (int i = 0; i < 40 && m_st != 3 && m_st != 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; seq_done = 1'b0; miss = 1'b0;
    @(negedge clk);

    // Reset held two cycles
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Start, show window, then clear level 0
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    run_to_play();
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    run_to_play();

    // Timeout penalty: no input through the whole PLAY window
    for (int i = 0; i < ROUND_N + 2; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run_to_play();

    // Misses until game over
    for (int i = 0; i < 12 && m_st != 6; i++) begin
      run_to_play();
      if (m_st == 3) cycle(1'b1, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
    end
    cycle(1'b1, 1'b0, 1'b1, 1'b1);

    // Restart and climb to level 3, finishing with seq_done and miss together
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    for (int l = 0; l < 3; l++) begin
      run_to_play();
      cycle(1'b1, 1'b0, 1'b1, 1'b0);
    end
    run_to_play();
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1);

    // Mid-game reset beats start and every other input
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    run_to_play();
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(logic'($urandom_range(0, 199) != 0),
            logic'($urandom_range(0, 15) == 0),
            logic'($urandom_range(0, 19) == 0),
            logic'($urandom_range(0, 14) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
